// File: rtl/ss_display_arbiter.sv
// ss_display_arbiter: round-robin owner selection for a shared 4-digit display, with minimum dwell and a scan tick
module ss_display_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DWELL = 50_000_000,
  parameter int SCAN_DIV = 100_000,
  parameter logic [15:0] IDLE_VALUE = 16'h0000
) (
  input  logic                     clk_i,
  input  logic                     reset_ni,
  input  logic [NUM_REQ-1:0]       req_i,
  input  logic [NUM_REQ-1:0][15:0] data_i,
  output logic [NUM_REQ-1:0]       grant_o,
  output logic [3:0][3:0]          bin_o,
  output logic                     scan_en_o,
  output logic                     busy_o
);
  localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  localparam int DW = $clog2(DWELL);
  localparam int SW = $clog2(SCAN_DIV);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] OWNED = 1'b1;
  logic [0:0] state;
  logic [IW-1:0] owner, rr_ptr, win;
  logic [DW-1:0] dwell_cnt;
  logic [SW-1:0] scan_cnt;
  logic rel, pre, take;
  assign busy_o = state == OWNED;
  assign rel = state == OWNED && !(|(req_i & grant_o));
  assign pre = state == OWNED && dwell_cnt == DW'(DWELL - 1) && |(req_i & ~grant_o);
  assign take = ((state == IDLE || rel) && |req_i) || pre;
  // first requesting index at or after rr_ptr, wrapping; the owner sits last since rr_ptr is owner+1
  always_comb begin
    win = rr_ptr;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (req_i[(int'(rr_ptr) + i) % NUM_REQ]) win = IW'((int'(rr_ptr) + i) % NUM_REQ);
  end
  // free-running scan divider, pulse on the cycle after the terminal count
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      scan_cnt <= '0;
      scan_en_o <= 1'b0;
    end else begin
      scan_cnt <= scan_cnt == SW'(SCAN_DIV - 1) ? '0 : scan_cnt + 1'b1;
      scan_en_o <= scan_cnt == SW'(SCAN_DIV - 1);
    end
  end
  // ownership: grant or hand off, release to idle, otherwise track owner data and age the dwell
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state <= IDLE;
      owner <= '0;
      rr_ptr <= '0;
      dwell_cnt <= '0;
      grant_o <= '0;
      bin_o <= IDLE_VALUE;
    end else if (take) begin
      state <= OWNED;
      owner <= win;
      rr_ptr <= int'(win) == NUM_REQ - 1 ? '0 : win + 1'b1;
      dwell_cnt <= '0;
      grant_o <= NUM_REQ'(1) << win;
      bin_o <= data_i[win];
    end else if (rel) begin
      state <= IDLE;
      grant_o <= '0;
      bin_o <= IDLE_VALUE;
    end else if (state == OWNED) begin
      bin_o <= data_i[owner];
      dwell_cnt <= dwell_cnt == DW'(DWELL - 1) ? dwell_cnt : dwell_cnt + 1'b1;
    end
  end
endmodule
